// File: rtl/spi_arb_pkg.sv
// Shared types for the two-requester SPI master arbiter.
// Holds the arbiter state encoding and the requester count.
package spi_arb_pkg;

  localparam int NumReq = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2,
    GUARD = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin pick; zero latency.
// On a tie the requester that did not win last time is chosen.
module rr_arbiter2
  import spi_arb_pkg::*;
(
  input  logic [NumReq-1:0] req,
  input  logic              last,
  output logic              any,
  output logic              winner
);

  always_comb begin
    any    = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI master between two requesters, grant held per transaction.
// Grant one cycle after request; strobes muxed combinationally; bus drained plus one guard cycle between grants.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int HoldWidth = 16
) (
  input  logic                 Clk_i,
  input  logic                 Reset_i,
  input  logic [NumReq-1:0]    Req_i,
  output logic [NumReq-1:0]    Gnt_o,
  input  logic [NumReq-1:0]    ReqWrite_i,
  input  logic [NumReq-1:0]    ReqReadNext_i,
  input  logic [7:0]           ReqData0_i,
  input  logic [7:0]           ReqData1_i,
  input  logic [NumReq-1:0]    ReqCPOL_i,
  input  logic [NumReq-1:0]    ReqCPHA_i,
  input  logic [NumReq-1:0]    ReqLSBFE_i,
  output logic                 SPI_Write_o,
  output logic                 SPI_ReadNext_o,
  output logic [7:0]           SPI_Data_o,
  output logic                 SPI_CPOL_o,
  output logic                 SPI_CPHA_o,
  output logic                 SPI_LSBFE_o,
  input  logic                 SPI_FIFOFull_i,
  input  logic                 SPI_FIFOEmpty_i,
  input  logic                 SPI_Transmission_i,
  input  logic [HoldWidth-1:0] HoldLimit_i,
  output logic                 Timeout_o,
  output logic                 Collision_o
);

  arb_state_e            state_q, state_d;
  logic                  last_q;
  logic [NumReq-1:0]     blocked_q;
  logic [HoldWidth-1:0]  cnt_q, cnt_inc;
  logic                  cpol_q, cpha_q, lsbfe_q;
  logic                  gidx, live, bus_quiet, hold_hit, drained, timeout_d;
  logic                  arb_any, arb_win;

  rr_arbiter2 u_rr (
    .req    (Req_i & ~blocked_q),
    .last   (last_q),
    .any    (arb_any),
    .winner (arb_win)
  );

  // Strobes are only forwarded while the owner still holds its request,
  // so anything issued in the release cycle never reaches the master.
  always_comb begin
    gidx           = Gnt_o[1];
    live           = (state_q == GRANT) && Req_i[gidx];
    SPI_Write_o    = live && ReqWrite_i[gidx];
    SPI_ReadNext_o = live && ReqReadNext_i[gidx];
    SPI_Data_o     = '0;
    if (live) begin
      SPI_Data_o = gidx ? ReqData1_i : ReqData0_i;
    end
    bus_quiet = !SPI_Transmission_i && SPI_FIFOEmpty_i && !SPI_Write_o && !SPI_ReadNext_o;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + {{(HoldWidth-1){1'b0}}, 1'b1};
    hold_hit  = (HoldLimit_i != '0) && bus_quiet && (cnt_inc == HoldLimit_i);
    timeout_d = live && hold_hit;
    // A full FIFO is never drained, even if the empty flag glitches with it.
    drained   = !SPI_Transmission_i && SPI_FIFOEmpty_i && !SPI_FIFOFull_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = GRANT;
      GRANT:   if (!Req_i[gidx] || hold_hit) state_d = DRAIN;
      DRAIN:   if (drained) state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign SPI_CPOL_o  = cpol_q;
  assign SPI_CPHA_o  = cpha_q;
  assign SPI_LSBFE_o = lsbfe_q;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q     <= IDLE;
      Gnt_o       <= '0;
      last_q      <= 1'b1;
      blocked_q   <= '0;
      cnt_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsbfe_q     <= 1'b0;
      Timeout_o   <= 1'b0;
      Collision_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      Timeout_o   <= timeout_d;
      Collision_o <= |((ReqWrite_i | ReqReadNext_i) & ~Gnt_o);
      blocked_q   <= blocked_q & Req_i;
      if (timeout_d) begin
        blocked_q[gidx] <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            Gnt_o   <= arb_win ? 2'b10 : 2'b01;
            last_q  <= arb_win;
            cpol_q  <= ReqCPOL_i[arb_win];
            cpha_q  <= ReqCPHA_i[arb_win];
            lsbfe_q <= ReqLSBFE_i[arb_win];
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (state_d == DRAIN) begin
            Gnt_o <= '0;
          end else begin
            cnt_q <= bus_quiet ? cnt_inc : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Shares the single SPI master between two requesting sensor controllers (e.g. two ADT7310-style SPI FSMs on the same reconfigurable module). Grants are round-robin and held for a whole multi-byte transaction. The muxed SPI strobes, TX byte and clock-mode bits of the granted requester drive the master. After release, the bus is drained before the next grant, so CPOL/CPHA/LSBFE never change mid-transfer. An idle-hold watchdog reclaims the bus from a requester that stalls while granted.

## Interface
- HoldWidth, 16: width of hold-limit watchdog counter and HoldLimit_i.
- Clk_i  in  1  system clock, all logic rising-edge.
- Reset_i  in  1  synchronous, active-high reset.
- Req_i  in  2  per-requester bus request, level; bit n = requester n.
- Gnt_o  out  2  one-hot-or-zero grant, registered.
- ReqWrite_i  in  2  per-requester SPI_Write strobe.
- ReqReadNext_i  in  2  per-requester SPI_ReadNext strobe.
- ReqData0_i  in  8  TX byte, requester 0.
- ReqData1_i  in  8  TX byte, requester 1.
- ReqCPOL_i, ReqCPHA_i, ReqLSBFE_i  in  2 each  per-requester clock-mode bits.
- SPI_Write_o, SPI_ReadNext_o  out  1  to SPI master.
- SPI_Data_o  out  8  to SPI master TX FIFO.
- SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o  out  1  to SPI master.
- SPI_FIFOFull_i, SPI_FIFOEmpty_i, SPI_Transmission_i  in  1  SPI master status.
- HoldLimit_i  in  HoldWidth  max idle cycles while granted; 0 disables watchdog.
- Timeout_o  out  1  one-cycle pulse when the watchdog revokes a grant.
- Collision_o  out  1  one-cycle pulse when a non-granted requester strobes Write/ReadNext.

## Operation
- States: IDLE, GRANT, DRAIN, GUARD.
- IDLE:
  - if any Req_i is set, go to GRANT, set Gnt_o to the winner and set Last_q to the winner.
  - Winner: the only requester asking, or, if both ask, the one not equal to Last_q.
- GRANT:
  - mux SPI_Write_o, SPI_ReadNext_o and SPI_Data_o combinationally from the granted requester's inputs.
  - drive the CPOL/CPHA/LSBFE outputs from registered copies captured on entry to GRANT. They stay stable for the whole grant.
  - on Req_i[granted]=0, go to DRAIN and clear Gnt_o.
- DRAIN: leave for GUARD when SPI_Transmission_i=0 and SPI_FIFOEmpty_i=1.
- GUARD: one cycle, then IDLE. Requests are not sampled in GUARD.
- Strobes and TX byte:
  - outside GRANT, SPI_Write_o=0, SPI_ReadNext_o=0 and SPI_Data_o=0.
  - strobes from the non-granted requester are discarded and pulse Collision_o. The pulse is registered: one cycle after the strobe.
- Clock-mode bits keep the last granted values through DRAIN/GUARD/IDLE.
- Watchdog:
  - counter clears on entry to GRANT.
  - in GRANT it increments each cycle that SPI_Transmission_i=0, SPI_FIFOEmpty_i=1 and neither strobe is active; any activity clears it.
  - when HoldLimit_i≠0 and the counter equals HoldLimit_i: force DRAIN, clear Gnt_o, pulse Timeout_o.
  - the counter saturates, never wraps.
- Revoked requester:
  - receives no new grant until it deasserts Req_i for at least one cycle. Track this with a per-requester Blocked_q bit.
  - Blocked_q clears when the corresponding Req_i=0.
- Reset (any state, mid-transfer included):
  - state IDLE, Gnt_o=0, Last_q=1 (requester 0 wins first tie).
  - all SPI outputs 0, CPOL/CPHA/LSBFE 0, counter 0, Blocked_q=0, Timeout_o=0, Collision_o=0.

## Timing
- Req_i rising in IDLE at edge t → Gnt_o=1 after edge t+1. Earliest muxed strobe reaches the master in the cycle after that.
- Release: Req_i falls at edge t → Gnt_o=0 after edge t+1. Any strobe in the release cycle is discarded.
- Minimum handover, bus already drained: release → IDLE in 3 cycles (DRAIN, GUARD, IDLE). The other grant follows 1 cycle later.
- Timeout_o asserts in the same cycle the state becomes DRAIN.
- Simultaneous release of one requester and request of the other: the new grant waits for the DRAIN/GUARD sequence.
- Req_i dropping and re-rising within DRAIN/GUARD: treated as a fresh request, arbitrated in IDLE against Last_q.

## Structure
- Shared package spi_arb_pkg: state enum (IDLE, GRANT, DRAIN, GUARD) and requester-count constant 2.
- One natural sub-module: rr_arbiter2, the combinational 2-way round-robin pick from Req_i & ~Blocked_q and Last_q.
- Everything else (FSM, mux, mode-bit registers, watchdog) lives in the top module.

## Test plan
- Single requester: Req_i=01 → Gnt_o=01 one cycle later. Write 0x50 then ReadNext ×2 appear on SPI_Data_o/strobes. Release → Gnt_o=00 and the bus reaches IDLE after Transmission=0 and FIFOEmpty=1.
- Both request after reset: Req_i=11 → requester 0 granted. On release, requester 1 is granted exactly 4 cycles after release with the bus drained. Next tie goes to requester 0.
- Mode isolation: requester 0 has CPOL=1, CPHA=1; requester 1 has CPOL=0, CPHA=0. Hold SPI_Transmission_i=1 for 10 cycles after release → outputs stay 1/1 until requester 1's grant.
- Collision: while requester 0 is granted, requester 1 pulses Write with Data 0xFF → SPI_Write_o stays 0, Collision_o pulses once, SPI_Data_o unaffected.
- Watchdog: HoldLimit_i=5, requester 0 granted and idle → Timeout_o pulse, Gnt_o=00 on the 5th idle cycle. Requester 0 is ignored until Req_i drops for 1 cycle. With HoldLimit_i=0, no timeout after 1000 cycles.
- Reset mid-transfer: assert Reset_i during GRANT with Write high → next cycle Gnt_o=0, all SPI outputs 0, state IDLE, requester 0 wins the next tie.
